// File: rtl/imm_ext_stage.sv
// Decode-side immediate extension stage: extracts the low IMM_W bits of an
// instruction, sign/zero-extends them and forwards both through a 2-entry skid buffer.
module imm_ext_stage #(
  parameter int INSTR_W = 32,
  parameter int IMM_W   = 16,
  parameter int OUT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_zext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OUT_W-1:0]   out_imm
);

  if (!(OUT_W > IMM_W && INSTR_W >= IMM_W)) begin : g_bad_params
    $error("imm_ext_stage: need OUT_W > IMM_W and INSTR_W >= IMM_W");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state, state_next;
  logic [INSTR_W-1:0] skid_instr;
  logic [OUT_W-1:0]   skid_imm;
  logic [IMM_W-1:0]   imm;
  logic [OUT_W-1:0]   ext_imm;
  logic               in_acc, out_con;
  logic               load_main, load_skid, main_from_skid;

  // Extension happens before capture so both registers hold finished results.
  assign imm     = in_instr[IMM_W-1:0];
  assign ext_imm = {{(OUT_W-IMM_W){~in_zext & imm[IMM_W-1]}}, imm};

  assign out_valid = (state != EMPTY);
  assign in_acc    = in_valid && in_ready;
  assign out_con   = out_valid && out_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_acc) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_acc && out_con) begin
          load_main = 1'b1;
        end else if (in_acc) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (out_con) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_con) begin
          main_from_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  // NOTE: the data registers are reset too, because a defined zero output after reset is part of the contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr  <= '0;
      out_imm    <= '0;
      skid_instr <= '0;
      skid_imm   <= '0;
    end else begin
      if (load_main) begin
        out_instr <= in_instr;
        out_imm   <= ext_imm;
      end else if (main_from_skid) begin
        out_instr <= skid_instr;
        out_imm   <= skid_imm;
      end
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_imm   <= ext_imm;
      end
    end
  end

endmodule
